// File: rtl/cnn_frame_feeder.sv
// Frame feeder between a host pixel stream and a CNN core: buffers one frame,
// streams it to the CNN on demand, then holds the classification until the host takes it.
module cnn_frame_feeder #(
    parameter int NPIX    = 784,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pix_valid,
    input  logic signed [31:0] pix_data,
    output logic               pix_ready,
    output logic               cnn_start,
    output logic signed [31:0] cnn_din,
    input  logic               cnn_din_ready,
    input  logic [9:0]         cnn_classes,
    input  logic               cnn_done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_class,
    output logic [9:0]         res_raw,
    output logic               res_err,
    output logic               busy
);
    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST    = IW'(NPIX - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {LOAD, START, STREAM, WAIT, RESULT} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      wr_idx, rd_idx;
    logic [TW-1:0]      tmo_cnt;
    logic               wr_en, rd_adv, cap, cap_err, tmo_abort;
    logic signed [31:0] frame_buf [NPIX];

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= LOAD;
        else       state <= state_n;
    end

    // A done seen while still streaming wins over a same-cycle consume and is flagged as early.
    always_comb begin
        state_n   = state;
        wr_en     = 1'b0;
        rd_adv    = 1'b0;
        cap       = 1'b0;
        cap_err   = 1'b0;
        tmo_abort = 1'b0;
        case (state)
            LOAD: begin
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST) state_n = START;
                end
            end
            START: state_n = STREAM;
            STREAM: begin
                if (cnn_done) begin
                    cap     = 1'b1;
                    cap_err = 1'b1;
                    state_n = RESULT;
                end else if (cnn_din_ready) begin
                    rd_adv = 1'b1;
                    if (rd_idx == LAST) state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnn_done) begin
                    cap     = 1'b1;
                    cap_err = ~is_onehot(cnn_classes);
                    state_n = RESULT;
                end else if (tmo_cnt == TMO_MAX) begin
                    tmo_abort = 1'b1;
                    state_n   = RESULT;
                end
            end
            RESULT: if (res_ready) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            tmo_cnt <= '0;
            res_raw <= '0;
            res_err <= 1'b0;
        end else begin
            if (wr_en) wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;

            if (state == START)  rd_idx <= '0;
            else if (rd_adv)     rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;

            // Zero outside WAIT, so the count always starts fresh on entry.
            if (state != WAIT)            tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)  tmo_cnt <= tmo_cnt + 1'b1;

            if (cap) begin
                res_raw <= cnn_classes;
                res_err <= cap_err;
            end else if (tmo_abort) begin
                res_raw <= '0;
                res_err <= 1'b1;
            end
        end
    end

    // Pixel storage carries no reset; a new frame simply overwrites it.
    always_ff @(posedge clk) begin
        if (wr_en) frame_buf[wr_idx] <= pix_data;
    end

    always_comb begin
        res_class = 4'd15;
        for (int i = 9; i >= 0; i--)
            if (res_raw[i]) res_class = 4'(i);
    end

    assign pix_ready = (state == LOAD);
    assign cnn_start = (state == START);
    assign res_valid = (state == RESULT);
    assign cnn_din   = (state == STREAM) ? frame_buf[rd_idx] : 32'sd0;
    assign busy      = !((state == LOAD) && (wr_idx == '0));

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Bench for cnn_frame_feeder: directed frame scenarios with randomized data and
// handshakes, checked against a frame-array and class-vector reference model.
module tb_cnn_frame_feeder;
    localparam int NPIX = 784;
    localparam int TMO  = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               pix_valid = 1'b0;
    logic signed [31:0] pix_data = '0;
    logic               pix_ready;
    logic               cnn_start;
    logic signed [31:0] cnn_din;
    logic               cnn_din_ready = 1'b0;
    logic [9:0]         cnn_classes = '0;
    logic               cnn_done = 1'b0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [3:0]         res_class;
    logic [9:0]         res_raw;
    logic               res_err;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic signed [31:0] frame [NPIX];

    cnn_frame_feeder #(.NPIX(NPIX), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .cnn_start(cnn_start), .cnn_din(cnn_din), .cnn_din_ready(cnn_din_ready),
        .cnn_classes(cnn_classes), .cnn_done(cnn_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_raw(res_raw), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model of the result rules
    function automatic int exp_class(input logic [9:0] c);
        for (int i = 0; i < 10; i++) if ((c >> i) & 10'd1) return i;
        return 15;
    endfunction

    function automatic bit exp_err(input logic [9:0] c, input bit forced);
        return forced || ($countones(c) != 1);
    endfunction

    function automatic logic [9:0] rand_onehot();
        return 10'(1 << $urandom_range(0, 9));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < NPIX; i++) frame[i] = i;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) frame[i] = $urandom;
    endtask

    // Writes frame[0..stop_at-1]; CNN-side inputs are noise and must be ignored.
    task automatic load_frame(input bit gaps, input int stop_at);
        int i = 0;
        int bad_din = 0;
        int bad_rdy = 0;
        while (i < stop_at) begin
            pix_valid     = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data      = frame[i];
            cnn_done      = 1'($urandom);
            cnn_din_ready = 1'($urandom);
            cnn_classes   = 10'($urandom);
            if (cnn_din !== 32'sd0) bad_din++;
            if (pix_ready !== 1'b1) bad_rdy++;
            @(posedge clk);
            if (pix_valid) i++;
            #1;
        end
        pix_valid = 1'b0;
        cnn_done  = 1'b0;
        check("load_din_zero", bad_din, 0);
        check("load_pix_ready", bad_rdy, 0);
    endtask

    task automatic expect_start();
        check("start_pulse", cnn_start, 1);
        check("start_pix_ready", pix_ready, 0);
        check("start_din_zero", cnn_din, 0);
        cnn_done      = 1'b1;
        cnn_din_ready = 1'b1;
        tick();
        check("start_one_cycle", cnn_start, 0);
    endtask

    // mode 0: ready always, 1: toggled 1/0, 2: random. early_at<0 means no early done.
    task automatic stream(input int mode, input int early_at, input logic [9:0] ecls);
        int  k = 0;
        int  cyc = 0;
        int  bad = 0;
        int  first_bad = -1;
        bit  ph = 1'b1;
        bit  left = 1'b0;
        while (k < NPIX && !left && cyc < 4 * NPIX) begin
            case (mode)
                0:       cnn_din_ready = 1'b1;
                1:       begin cnn_din_ready = ph; ph = ~ph; end
                default: cnn_din_ready = 1'($urandom);
            endcase
            cnn_done    = (k == early_at);
            cnn_classes = cnn_done ? ecls : 10'($urandom);
            if (cnn_din !== frame[k]) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            @(posedge clk);
            if (cnn_done) left = 1'b1;
            else if (cnn_din_ready) k++;
            #1;
            cyc++;
        end
        cnn_done      = 1'b0;
        cnn_din_ready = 1'b0;
        check("stream_din_order", bad, 0);
        if (bad != 0) $display("  first bad stream index %0d", first_bad);
        check("stream_in_bound", cyc < 4 * NPIX, 1);
        if (early_at >= 0) begin
            check("early_consumes", k, early_at);
            check("early_to_result", res_valid, 1);
        end else begin
            check("stream_consumes", k, NPIX);
            check("wait_no_result", res_valid, 0);
            check("wait_din_zero", cnn_din, 0);
        end
    endtask

    task automatic finish_wait(input int delay, input logic [9:0] cls);
        cnn_done = 1'b0;
        repeat (delay) begin
            cnn_classes   = 10'($urandom);
            cnn_din_ready = 1'($urandom);
            tick();
        end
        check("wait_hold_before_done", res_valid, 0);
        cnn_done    = 1'b1;
        cnn_classes = cls;
        tick();
        cnn_done      = 1'b0;
        cnn_din_ready = 1'b0;
    endtask

    task automatic check_result(input logic [9:0] raw, input bit forced);
        check("res_valid", res_valid, 1);
        check("res_raw", res_raw, raw);
        check("res_class", res_class, exp_class(raw));
        check("res_err", res_err, exp_err(raw, forced));
        check("res_busy", busy, 1);
        check("res_pix_ready", pix_ready, 0);
    endtask

    // Holds off the host for `hold` cycles while pixels and done are offered, then accepts.
    task automatic handshake(input int hold);
        logic [9:0] s_raw = res_raw;
        logic [3:0] s_cls = res_class;
        logic       s_err = res_err;
        int         bad = 0;
        int         rdy_bad = 0;
        repeat (hold) begin
            res_ready   = 1'b0;
            pix_valid   = 1'b1;
            pix_data    = $urandom;
            cnn_done    = 1'b1;
            cnn_classes = 10'($urandom);
            tick();
            if (res_valid !== 1'b1 || res_raw !== s_raw || res_class !== s_cls || res_err !== s_err) bad++;
            if (pix_ready !== 1'b0) rdy_bad++;
        end
        pix_valid = 1'b0;
        cnn_done  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (hold > 0) begin
            check("hold_stable", bad, 0);
            check("hold_pix_ready", rdy_bad, 0);
        end
        check("back_to_load_valid", res_valid, 0);
        check("back_to_load_ready", pix_ready, 1);
        check("back_to_load_idle", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 1);
        check({tag, "_cnn_start"}, cnn_start, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_cnn_din"}, cnn_din, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_raw"}, res_raw, 0);
        check({tag, "_res_err"}, res_err, 0);
        check({tag, "_res_class"}, res_class, 15);
    endtask

    initial begin
        logic [9:0] cls;
        int         cnt;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Frame 1: sequential pixels, ready always high, class 3
        fill_seq();
        load_frame(1'b0, NPIX);
        expect_start();
        stream(0, -1, '0);
        finish_wait($urandom_range(0, 15), 10'b0000001000);
        check_result(10'b0000001000, 1'b0);
        check("f1_class_is_3", res_class, 3);
        check("f1_err_clear", res_err, 0);
        handshake(0);

        // Frame 2: same frame, ready toggled
        fill_seq();
        load_frame(1'b0, NPIX);
        expect_start();
        stream(1, -1, '0);
        cls = rand_onehot();
        finish_wait($urandom_range(0, 15), cls);
        check_result(cls, 1'b0);
        handshake(0);

        // Frame 3: two bits set, host stalls the result for 5 cycles
        fill_rand();
        load_frame(1'b1, NPIX);
        expect_start();
        stream(2, -1, '0);
        finish_wait($urandom_range(0, 15), 10'b0000010010);
        check_result(10'b0000010010, 1'b0);
        check("f3_class_is_1", res_class, 1);
        handshake(5);

        // Frame 4: empty class vector
        fill_rand();
        load_frame(1'b0, NPIX);
        expect_start();
        stream(0, -1, '0);
        finish_wait($urandom_range(0, 15), 10'b0);
        check_result(10'b0, 1'b0);
        handshake(2);

        // Frame 5: no done at all -> timeout abort 17 cycles into WAIT
        fill_rand();
        load_frame(1'b0, NPIX);
        expect_start();
        stream(2, -1, '0);
        cnt = 0;
        while (res_valid !== 1'b1 && cnt < 100) begin
            cnn_classes = 10'($urandom);
            tick();
            cnt++;
        end
        check("timeout_latency", cnt, TMO + 1);
        check_result(10'b0, 1'b1);
        handshake(1);

        // Frame 6: early done mid-stream with a valid one-hot vector
        fill_rand();
        load_frame(1'b1, NPIX);
        expect_start();
        cls = rand_onehot();
        stream(2, $urandom_range(1, NPIX - 2), cls);
        check_result(cls, 1'b1);
        handshake(0);

        // Frame 7: done coincides with the final consume
        fill_rand();
        load_frame(1'b0, NPIX);
        expect_start();
        cls = rand_onehot();
        stream(0, NPIX - 1, cls);
        check_result(cls, 1'b1);
        handshake(0);

        // Frame 8: arbitrary class vector
        fill_rand();
        load_frame(1'b1, NPIX);
        expect_start();
        stream(2, -1, '0);
        cls = 10'($urandom);
        finish_wait($urandom_range(0, 15), cls);
        check_result(cls, 1'b0);
        handshake(3);

        // Reset pulse part-way through a load, then a full fresh frame
        fill_rand();
        load_frame(1'b0, 400);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rstn = 1'b1;
        tick();
        fill_rand();
        load_frame(1'b0, NPIX);
        expect_start();
        stream(2, -1, '0);
        cls = rand_onehot();
        finish_wait($urandom_range(0, 15), cls);
        check_result(cls, 1'b0);
        handshake(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
